// File: rtl/icache_line_fetcher_if.sv
// Bundles the I-cache miss port (dfp_*) and the burst DRAM port (bmem_*).
// The master modport is the line fetcher itself; slave is the cache/DRAM side.
interface icache_line_fetcher_if #(
  parameter int ADDR_W    = 32,
  parameter int BEAT_W    = 64,
  parameter int BURST_LEN = 4
);
  localparam int LINE_W = BEAT_W * BURST_LEN;

  logic [ADDR_W-1:0] dfp_addr;
  logic              dfp_read;
  logic [LINE_W-1:0] dfp_rdata;
  logic              dfp_resp;

  logic [ADDR_W-1:0] bmem_addr;
  logic              bmem_read;
  logic              bmem_ready;
  logic [ADDR_W-1:0] bmem_raddr;
  logic [BEAT_W-1:0] bmem_rdata;
  logic              bmem_rvalid;

  modport master (
    input  dfp_addr, dfp_read, bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
    output dfp_rdata, dfp_resp, bmem_addr, bmem_read
  );

  modport slave (
    output dfp_addr, dfp_read, bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
    input  dfp_rdata, dfp_resp, bmem_addr, bmem_read
  );
endinterface

// File: rtl/icache_line_fetcher.sv
// Read-only line fetcher: turns one I-cache line miss into a single DRAM burst
// and hands back the assembled line with a one-cycle response pulse.
module icache_line_fetcher #(
  parameter int ADDR_W    = 32,
  parameter int BEAT_W    = 64,
  parameter int BURST_LEN = 4
) (
  input logic clk,
  input logic rst,
  icache_line_fetcher_if.master bus
);
  localparam int LINE_W     = BEAT_W * BURST_LEN;
  localparam int LINE_BYTES = LINE_W / 8;
  localparam int CNT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BURST_LEN - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_BYTES - 1);

  typedef enum logic [1:0] {IDLE, REQ, BURST, RESP} state_t;

  state_t            state, next_state;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] line_q;
  logic              settle;
  logic              accept;
  logic              beat_hit;

  always_comb begin
    next_state    = state;
    bus.bmem_read = 1'b0;
    bus.dfp_resp  = 1'b0;
    accept        = 1'b0;
    beat_hit      = 1'b0;
    case (state)
      IDLE: begin
        // The cycle right after a response is blind so a still-high dfp_read
        // cannot start a duplicate burst.
        accept = bus.dfp_read && !settle;
        if (accept) next_state = REQ;
      end
      REQ: begin
        bus.bmem_read = 1'b1;
        if (bus.bmem_ready) next_state = BURST;
      end
      BURST: begin
        beat_hit = bus.bmem_rvalid && (bus.bmem_raddr == addr_q);
        if (beat_hit && count == LAST_BEAT) next_state = RESP;
      end
      RESP: begin
        bus.dfp_resp = 1'b1;
        next_state   = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      count  <= '0;
      addr_q <= '0;
      line_q <= '0;
      settle <= 1'b0;
    end else begin
      state  <= next_state;
      settle <= (state == RESP);
      if (accept) addr_q <= bus.dfp_addr & LINE_MASK;
      if (state == REQ) count <= '0;
      // The counter holds on the final beat instead of wrapping mid-burst.
      if (beat_hit) begin
        line_q[count*BEAT_W +: BEAT_W] <= bus.bmem_rdata;
        if (count != LAST_BEAT) count <= count + 1'b1;
      end
    end
  end

  assign bus.bmem_addr = addr_q;
  assign bus.dfp_rdata = line_q;
endmodule
